lod_shift_norm: RTL and testbench

- Front-end normalizer for the 16b fractional log path. It sits directly upstream of the log-offset LUT stage.
- Finds the leading one of an unsigned 16-bit fraction and produces the 4-bit shift_offset that the LUT consumes.
- Also produces the left-normalized mantissa and a zero flag.
- 2-stage valid/ready pipeline with full throughput and backpressure, plus a saturating count of accepted operands.

---
 rtl/log_norm_pkg.sv | 11 +
 rtl/lod16.sv | 23 ++
 rtl/lod_shift_norm.sv | 93 +++++++++
 tb/tb_lod_shift_norm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_norm_pkg.sv
// Shared widths and types for the 16b fractional log path.
// The LUT stage imports shift_t so its shift_offset input matches this block's output.
package log_norm_pkg;

  localparam int DATA_W  = 16;
  localparam int SHIFT_W = $clog2(DATA_W);

  typedef logic [SHIFT_W-1:0] shift_t;
  typedef logic [DATA_W-1:0]  frac_t;

endpackage

// File: rtl/lod16.sv
// Leading-one detector: index of the most significant set bit, plus a zero flag.
// Purely combinational so any pipeline stage can reuse it.
module lod16
  import log_norm_pkg::*;
(
  input  frac_t  data,
  output shift_t pos,
  output logic   zero
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves it unassigned would infer a latch.
    pos = '0;
    // Ascending scan, so the highest set bit is the last one to write pos.
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) pos = shift_t'(i);
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/lod_shift_norm.sv
// Two-stage valid/ready normalizer: leading-one index in stage 1, shift offset and
// left-normalized mantissa in stage 2, plus a saturating accepted-operand counter.
module lod_shift_norm #(
  parameter int DATA_W  = log_norm_pkg::DATA_W,
  parameter int SHIFT_W = log_norm_pkg::SHIFT_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_cnt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHIFT_W-1:0] out_shift_offset,
  output logic [DATA_W-1:0]  out_mant,
  output logic               out_zero,
  output logic [CNT_W-1:0]   op_cnt
);

  logic               s1_valid, s2_valid;
  logic               s1_en, s2_en, accept;
  logic [DATA_W-1:0]  s1_data;
  logic [SHIFT_W-1:0] s1_pos, s1_shift, lod_pos;
  logic               s1_zero, lod_zero;

  // A stage loads when it is empty or its contents move on this cycle.
  assign s2_en    = ~s2_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;
  assign accept   = in_valid & in_ready;

  lod16 u_lod (
    .data (in_data),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  // DATA_W is a power of two, so DATA_W-1-p is the bitwise inverse of p.
  // A zero operand has p=0, which yields shift = all ones and mant = 0.
  assign s1_shift = ~s1_pos;

  // NOTE: data registers are reset too, purely so outputs are deterministic
  // after reset; the valid bits alone are what make the pipeline correct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_pos   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_en) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_pos  <= lod_pos;
        s1_zero <= lod_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid         <= 1'b0;
      out_shift_offset <= '0;
      out_mant         <= '0;
      out_zero         <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_shift_offset <= s1_shift;
        out_mant         <= s1_data << s1_shift;
        out_zero         <= s1_zero;
      end
    end
  end

  assign out_valid = s2_valid;

  // Clear has priority over an accept in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt <= '0;
    end else if (clr_cnt) begin
      op_cnt <= '0;
    end else if (accept && (op_cnt != '1)) begin
      op_cnt <= op_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lod_shift_norm.sv
// Directed bench for lod_shift_norm; a second instance with a 3-bit counter
// exercises counter saturation within a few cycles.
module tb_lod_shift_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_cnt, sat_clr;
  logic        in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_zero;
  logic [3:0]  out_shift_offset;
  logic [15:0] out_mant, op_cnt;

  logic        s_in_ready, s_out_valid, s_out_zero;
  logic [3:0]  s_shift;
  logic [15:0] s_mant;
  logic [2:0]  s_op_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  lod_shift_norm dut (
    .clk              (clk),
    .rst              (rst),
    .clr_cnt          (clr_cnt),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_shift_offset (out_shift_offset),
    .out_mant         (out_mant),
    .out_zero         (out_zero),
    .op_cnt           (op_cnt)
  );

  lod_shift_norm #(.CNT_W(3)) dut_sat (
    .clk              (clk),
    .rst              (rst),
    .clr_cnt          (sat_clr),
    .in_valid         (in_valid),
    .in_ready         (s_in_ready),
    .in_data          (in_data),
    .out_valid        (s_out_valid),
    .out_ready        (out_ready),
    .out_shift_offset (s_shift),
    .out_mant         (s_mant),
    .out_zero         (s_out_zero),
    .op_cnt           (s_op_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_cnt = 1'b0; sat_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    vec_cnt++;
    if ({out_valid, out_shift_offset, out_mant, out_zero, op_cnt} !== 38'h0) begin
      miss_cnt++;
      $display("FAIL reset_state: got v=%b sh=%h m=%h z=%b cnt=%h want all zero",
               out_valid, out_shift_offset, out_mant, out_zero, op_cnt);
    end
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    #3 rst = 1'b0;
    tick();
  endtask

  // Back-to-back operands with out_ready=1: 2-cycle latency, 1 result per cycle.
  task automatic test_stream();
    logic [15:0] v_data [8] = '{16'h8000, 16'h0C35, 16'h0001, 16'h0000,
                                16'hFFFF, 16'h0003, 16'h00FF, 16'h0100};
    logic [3:0]  v_sh   [8] = '{4'd0, 4'd4, 4'd15, 4'd15, 4'd0, 4'd14, 4'd8, 4'd7};
    logic [15:0] v_mant [8] = '{16'h8000, 16'hC350, 16'h8000, 16'h0000,
                                16'hFFFF, 16'hC000, 16'hFF00, 16'h8000};
    logic        v_zero [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin
        vec_cnt++;
        if (out_valid !== 1'b0) begin
          miss_cnt++;
          $display("FAIL stream_latency: out_valid got %b after 1 cycle want 0", out_valid);
        end
      end
      if (c >= 2) begin
        vec_cnt++;
        if ({out_valid, out_shift_offset, out_mant, out_zero} !==
            {1'b1, v_sh[c-2], v_mant[c-2], v_zero[c-2]}) begin
          miss_cnt++;
          $display("FAIL stream_%0h: got v=%b sh=%0d m=%h z=%b want v=1 sh=%0d m=%h z=%b",
                   v_data[c-2], out_valid, out_shift_offset, out_mant, out_zero,
                   v_sh[c-2], v_mant[c-2], v_zero[c-2]);
        end
      end
      if (c < 8) begin
        vec_cnt++;
        if (in_ready !== 1'b1) begin
          miss_cnt++;
          $display("FAIL stream_in_ready: got %b want 1 at cycle %0d", in_ready, c);
        end
        in_valid = 1'b1; in_data = v_data[c];
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL stream_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_sh [2] = '{4'd10, 4'd1};
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0100;
    tick();
    in_data = 16'h0020;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL bp_second_accept: in_ready got %b want 1", in_ready);
    end
    tick();
    in_data = 16'h4000;
    for (int k = 0; k < 3; k++) begin
      vec_cnt++;
      if ({in_ready, out_valid, out_shift_offset, out_mant} !== {1'b0, 1'b1, 4'd7, 16'h8000}) begin
        miss_cnt++;
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b sh=%0d m=%h want rdy=0 v=1 sh=7 m=8000",
                 k, in_ready, out_valid, out_shift_offset, out_mant);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL bp_release_ready: in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vec_cnt++;
      if ({out_valid, out_shift_offset, out_mant, out_zero} !== {1'b1, exp_sh[k], 16'h8000, 1'b0}) begin
        miss_cnt++;
        $display("FAIL bp_order_%0d: got v=%b sh=%0d m=%h z=%b want v=1 sh=%0d m=8000 z=0",
                 k, out_valid, out_shift_offset, out_mant, out_zero, exp_sh[k]);
      end
      tick();
    end
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL bp_no_duplicate: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_op_cnt();
    out_ready = 1'b1; in_valid = 1'b0;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    vec_cnt++;
    if (op_cnt !== 16'd0) begin
      miss_cnt++;
      $display("FAIL cnt_clear: got %0d want 0", op_cnt);
    end
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 16'h0010 << k;
      tick();
    end
    vec_cnt++;
    if (op_cnt !== 16'd3) begin
      miss_cnt++;
      $display("FAIL cnt_three: got %0d want 3", op_cnt);
    end
    in_data = 16'h1234; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0; in_valid = 1'b0;
    vec_cnt++;
    if (op_cnt !== 16'd0) begin
      miss_cnt++;
      $display("FAIL cnt_clr_wins: got %0d want 0", op_cnt);
    end
    tick(); tick();
    vec_cnt++;
    if (op_cnt !== 16'd0) begin
      miss_cnt++;
      $display("FAIL cnt_after_clr: got %0d want 0", op_cnt);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; in_valid = 1'b0;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    in_valid = 1'b1; in_data = 16'h0042;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 6 || k == 7 || k == 9) begin
        vec_cnt++;
        if (s_op_cnt !== ((k > 7) ? 3'd7 : 3'(k))) begin
          miss_cnt++;
          $display("FAIL cnt_sat_%0d: got %0d want %0d", k, s_op_cnt, (k > 7) ? 7 : k);
        end
      end
    end
    in_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0100;
    tick();
    in_data = 16'h0020;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({out_valid, out_shift_offset, out_mant, out_zero, op_cnt} !== 38'h0) begin
      miss_cnt++;
      $display("FAIL rst_mid_async: got v=%b sh=%h m=%h z=%b cnt=%h want all zero",
               out_valid, out_shift_offset, out_mant, out_zero, op_cnt);
    end
    tick();
    #3 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 16'h0C35;
    tick();
    in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rst_mid_stale: out_valid got %b one cycle after accept want 0", out_valid);
    end
    tick();
    vec_cnt++;
    if ({out_valid, out_shift_offset, out_mant, out_zero, op_cnt} !==
        {1'b1, 4'd4, 16'hC350, 1'b0, 16'd1}) begin
      miss_cnt++;
      $display("FAIL rst_mid_first: got v=%b sh=%0d m=%h z=%b cnt=%0d want v=1 sh=4 m=C350 z=0 cnt=1",
               out_valid, out_shift_offset, out_mant, out_zero, op_cnt);
    end
    tick();
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rst_mid_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_op_cnt();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
